// File: rtl/mem_stage_if.sv
// Execute->memory payload, memory->writeback payload, data-SRAM response and
// decode forwarding bus of the memory stage.
interface mem_stage_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEST_W = 5
);
  logic              EM_valid;
  logic              M_allowin;
  logic [PC_W-1:0]   em_pc;
  logic [PC_W-1:0]   em_rf_wdata;
  logic              em_gr_we;
  logic [DEST_W-1:0] em_dest;
  logic [3:0]        em_res_from_mem;
  logic              em_load_unsigned;
  logic              em_mem_req;
  logic [1:0]        em_addr_lo;
  logic              em_ex;
  logic              ex_en;
  logic              W_allowin;
  logic              MW_valid;
  logic [PC_W-1:0]   mw_pc;
  logic [PC_W-1:0]   mw_rf_wdata;
  logic              mw_gr_we;
  logic [DEST_W-1:0] mw_dest;
  logic              mw_ex;
  logic              data_sram_data_ok;
  logic [PC_W-1:0]   data_sram_rdata;
  logic [DEST_W-1:0] md_fwd_dest;
  logic [PC_W-1:0]   md_fwd_data;
  logic              md_fwd_busy;

  modport master (
    output EM_valid, em_pc, em_rf_wdata, em_gr_we, em_dest, em_res_from_mem,
           em_load_unsigned, em_mem_req, em_addr_lo, em_ex, ex_en, W_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  M_allowin, MW_valid, mw_pc, mw_rf_wdata, mw_gr_we, mw_dest, mw_ex,
           md_fwd_dest, md_fwd_data, md_fwd_busy
  );

  modport slave (
    input  EM_valid, em_pc, em_rf_wdata, em_gr_we, em_dest, em_res_from_mem,
           em_load_unsigned, em_mem_req, em_addr_lo, em_ex, ex_en, W_allowin,
           data_sram_data_ok, data_sram_rdata,
    output M_allowin, MW_valid, mw_pc, mw_rf_wdata, mw_gr_we, mw_dest, mw_ex,
           md_fwd_dest, md_fwd_data, md_fwd_busy
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for owed data-SRAM responses, aligns and
// extends load data, forwards to decode and drops stale responses after a flush.
module mem_stage #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEST_W = 5
) (
  input logic        clk,
  input logic        rstn,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [1:0]        drop_q, drop_d;
  logic [2:0]        drop_sum;
  logic [PC_W-1:0]   pc_q, wdata_q, rbuf_q;
  logic              gr_we_q, uns_q, ex_q;
  logic [DEST_W-1:0] dest_q;
  logic [3:0]        res_q;
  logic [1:0]        lo_q;

  logic              in_wait, bypass, ready_go, allowin, capture, leave;
  logic [PC_W-1:0]   src_word, load_data;
  logic [15:0]       half_raw;

  assign in_wait  = m_valid_q && (state_q == StWait);
  // Response belongs to the current entry only when no stale ones are owed.
  assign bypass   = in_wait && bus.data_sram_data_ok && (drop_q == 2'd0);
  assign ready_go = m_valid_q && ((state_q == StIdle) || (state_q == StDone) || bypass);
  assign allowin  = !m_valid_q || (ready_go && bus.W_allowin);
  assign capture  = bus.EM_valid && allowin && !bus.ex_en;
  assign leave    = ready_go && bus.W_allowin;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    if (bus.ex_en) begin
      m_valid_d = 1'b0;
      state_d   = StIdle;
    end else begin
      if (bypass) state_d = StDone;
      if (leave)  state_d = StIdle;
      if (capture) begin
        m_valid_d = 1'b1;
        state_d   = bus.em_mem_req ? StWait : StIdle;
      end else if (allowin) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // A response arriving with a flush in WAIT is consumed by the flushed entry.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    if (bus.ex_en) begin
      drop_sum = drop_sum + 3'(in_wait) + 3'(bus.EM_valid && bus.em_mem_req);
    end
    if (bus.data_sram_data_ok && ((drop_q != 2'd0) || (bus.ex_en && in_wait))) begin
      drop_sum = drop_sum - 3'd1;
    end
    drop_d = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      m_valid_q <= 1'b0;
      drop_q    <= 2'd0;
      rbuf_q    <= '0;
      pc_q      <= '0;
      wdata_q   <= '0;
      gr_we_q   <= 1'b0;
      dest_q    <= '0;
      res_q     <= 4'd0;
      uns_q     <= 1'b0;
      lo_q      <= 2'd0;
      ex_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      drop_q    <= drop_d;
      if (bypass) rbuf_q <= bus.data_sram_rdata;
      if (capture) begin
        pc_q    <= bus.em_pc;
        wdata_q <= bus.em_rf_wdata;
        gr_we_q <= bus.em_gr_we;
        dest_q  <= bus.em_dest;
        res_q   <= bus.em_res_from_mem;
        uns_q   <= bus.em_load_unsigned;
        lo_q    <= bus.em_addr_lo;
        ex_q    <= bus.em_ex;
      end
    end
  end

  assign src_word = bypass ? bus.data_sram_rdata : rbuf_q;
  assign half_raw = 16'(src_word >> {lo_q, 3'b000});

  always_comb begin
    case (res_q)
      4'b0001: load_data = {{(PC_W-8){!uns_q && half_raw[7]}}, half_raw[7:0]};
      4'b0011: load_data = {{(PC_W-16){!uns_q && half_raw[15]}}, half_raw};
      default: load_data = src_word;
    endcase
  end

  assign bus.M_allowin   = allowin;
  assign bus.MW_valid    = ready_go;
  assign bus.mw_pc       = pc_q;
  assign bus.mw_rf_wdata = (res_q != 4'd0) ? load_data : wdata_q;
  assign bus.mw_gr_we    = gr_we_q && !ex_q;
  assign bus.mw_dest     = dest_q;
  assign bus.mw_ex       = ex_q;
  assign bus.md_fwd_dest = (m_valid_q && gr_we_q && !ex_q) ? dest_q : '0;
  assign bus.md_fwd_data = bus.mw_rf_wdata;
  assign bus.md_fwd_busy = m_valid_q && (res_q != 4'd0) && !ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_stage;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  mem_stage_if #(.PC_W(32), .DEST_W(5)) bus ();

  mem_stage #(.PC_W(32), .DEST_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
    end
  endtask

  // Load result as the shift/extract/extend rule describes it.
  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [3:0] res,
                                           input logic [1:0] lo, input bit uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> (8 * lo);
    case (res)
      4'b0001: begin r = sh & 32'hFF;   if (!uns && sh[7])  r = r | 32'hFFFF_FF00; end
      4'b0011: begin r = sh & 32'hFFFF; if (!uns && sh[15]) r = r | 32'hFFFF_0000; end
      default: r = word;
    endcase
    return r;
  endfunction

  // Model: one held entry, whether it still awaits its response, and stale count.
  bit          mv, mwait, m_we, m_uns, m_ex;
  logic [31:0] m_pc, m_wd, m_rbuf;
  logic [4:0]  m_dest;
  logic [3:0]  m_res;
  logic [1:0]  m_lo;
  int          drop;
  bit          e_allow;

  initial begin
    mv = 0; mwait = 0; drop = 0; m_rbuf = 0;
    m_we = 0; m_uns = 0; m_ex = 0; m_pc = 0; m_wd = 0; m_dest = 0; m_res = 0; m_lo = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        bit          byp, rdy, busy;
        logic [31:0] word, wd;
        logic [4:0]  fwd;
        byp     = mv && mwait && bus.data_sram_data_ok && (drop == 0);
        rdy     = mv && (!mwait || byp);
        word    = byp ? bus.data_sram_rdata : m_rbuf;
        wd      = (m_res != 0) ? load_val(word, m_res, m_lo, m_uns) : m_wd;
        e_allow = !mv || (rdy && bus.W_allowin);
        fwd     = (mv && m_we && !m_ex) ? m_dest : 5'd0;
        busy    = mv && (m_res != 0) && !rdy;
        chk("MW_valid", 32'(bus.MW_valid), 32'(rdy));
        chk("M_allowin", 32'(bus.M_allowin), 32'(e_allow));
        chk("md_fwd_busy", 32'(bus.md_fwd_busy), 32'(busy));
        chk("md_fwd_dest", 32'(bus.md_fwd_dest), 32'(fwd));
        if (rdy) begin
          chk("mw_pc", bus.mw_pc, m_pc);
          chk("mw_rf_wdata", bus.mw_rf_wdata, wd);
          chk("md_fwd_data", bus.md_fwd_data, wd);
          chk("mw_gr_we", 32'(bus.mw_gr_we), 32'(m_we && !m_ex));
          chk("mw_dest", 32'(bus.mw_dest), 32'(m_dest));
          chk("mw_ex", 32'(bus.mw_ex), 32'(m_ex));
        end
      end
      @(posedge clk);
      if (!rstn) begin
        mv = 0; mwait = 0; drop = 0; m_rbuf = 0;
        m_we = 0; m_uns = 0; m_ex = 0; m_pc = 0; m_wd = 0; m_dest = 0; m_res = 0; m_lo = 0;
      end else begin
        bit served;
        served = 0;
        if (bus.data_sram_data_ok) begin
          if (drop > 0) drop--;
          else if (mv && mwait) served = 1;
        end
        if (bus.ex_en) begin
          if (mv && mwait && !served) drop++;
          if (bus.EM_valid && bus.em_mem_req) drop++;
          if (drop > 3) drop = 3;
          mv = 0; mwait = 0;
        end else begin
          if (served) begin m_rbuf = bus.data_sram_rdata; mwait = 0; end
          if (e_allow) begin
            if (bus.EM_valid) begin
              mv = 1; mwait = bus.em_mem_req;
              m_pc = bus.em_pc; m_wd = bus.em_rf_wdata; m_we = bus.em_gr_we;
              m_dest = bus.em_dest; m_res = bus.em_res_from_mem;
              m_uns = bus.em_load_unsigned; m_lo = bus.em_addr_lo; m_ex = bus.em_ex;
            end else begin
              mv = 0;
            end
          end
        end
      end
    end
  end

  task automatic em_clear();
    bus.EM_valid   = 1'b0;
    bus.em_mem_req = 1'b0;
  endtask

  task automatic em_drive(input logic [31:0] pc, input logic [31:0] wd, input logic we,
                          input logic [4:0] dest, input logic [3:0] res, input logic uns,
                          input logic req, input logic [1:0] lo, input logic ex);
    bus.EM_valid = 1'b1; bus.em_pc = pc; bus.em_rf_wdata = wd; bus.em_gr_we = we;
    bus.em_dest = dest; bus.em_res_from_mem = res; bus.em_load_unsigned = uns;
    bus.em_mem_req = req; bus.em_addr_lo = lo; bus.em_ex = ex;
  endtask

  int outstanding = 0;
  bit hold = 0;

  initial begin
    rstn = 1'b0;
    em_drive(32'h0, 32'h0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    em_clear();
    bus.ex_en = 1'b0; bus.W_allowin = 1'b1;
    bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #2;
    chk("rst MW_valid", 32'(bus.MW_valid), 32'd0);
    chk("rst M_allowin", 32'(bus.M_allowin), 32'd1);
    chk("rst fwd_dest", 32'(bus.md_fwd_dest), 32'd0);
    chk("rst fwd_busy", 32'(bus.md_fwd_busy), 32'd0);
    chk("rst mw_pc", bus.mw_pc, 32'd0);
    chk("rst mw_rf_wdata", bus.mw_rf_wdata, 32'd0);

    // ALU op
    @(negedge clk); em_drive(32'h1c00_0000, 32'h1234_5678, 1'b1, 5'd5, 4'd0, 0, 0, 2'd0, 0);
    @(negedge clk); em_clear(); #2;
    chk("alu MW_valid", 32'(bus.MW_valid), 32'd1);
    chk("alu wdata", bus.mw_rf_wdata, 32'h1234_5678);
    chk("alu pc", bus.mw_pc, 32'h1c00_0000);
    chk("alu fwd_dest", 32'(bus.md_fwd_dest), 32'd5);
    chk("alu busy", 32'(bus.md_fwd_busy), 32'd0);

    // Signed then unsigned byte load at addr_lo=2, response 3 cycles later
    for (int u = 0; u < 2; u++) begin
      @(negedge clk); bus.data_sram_data_ok = 1'b0;
      em_drive(32'h1c00_0004, 32'h0, 1'b1, 5'd6, 4'b0001, u[0], 1'b1, 2'd2, 1'b0);
      repeat (3) begin
        @(negedge clk); em_clear(); #2;
        chk("lb busy", 32'(bus.md_fwd_busy), 32'd1);
        chk("lb MW_valid early", 32'(bus.MW_valid), 32'd0);
      end
      @(negedge clk); bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h0080_0000; #2;
      chk("lb MW_valid", 32'(bus.MW_valid), 32'd1);
      chk("lb wdata", bus.mw_rf_wdata, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb busy done", 32'(bus.md_fwd_busy), 32'd0);
    end

    // Half load whose response arrives during a writeback stall
    @(negedge clk); bus.data_sram_data_ok = 1'b0;
    em_drive(32'h1c00_0008, 32'h0, 1'b1, 5'd7, 4'b0011, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk); em_clear(); bus.W_allowin = 1'b0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hBEEF_0000; #2;
    chk("lh MW_valid", 32'(bus.MW_valid), 32'd1);
    chk("lh wdata", bus.mw_rf_wdata, 32'hFFFF_BEEF);
    chk("lh allowin stall", 32'(bus.M_allowin), 32'd0);
    @(negedge clk); bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = 32'h1357_9BDF; #2;
    chk("lh held MW_valid", 32'(bus.MW_valid), 32'd1);
    chk("lh held wdata", bus.mw_rf_wdata, 32'hFFFF_BEEF);
    chk("lh held allowin", 32'(bus.M_allowin), 32'd0);
    @(negedge clk); bus.W_allowin = 1'b1; #2;
    chk("lh release allowin", 32'(bus.M_allowin), 32'd1);
    chk("lh release wdata", bus.mw_rf_wdata, 32'hFFFF_BEEF);
    @(negedge clk); #2;
    chk("lh gone", 32'(bus.MW_valid), 32'd0);

    // Flush in WAIT; its late response must not satisfy the next load
    @(negedge clk); em_drive(32'h1c00_000c, 32'h0, 1'b1, 5'd8, 4'b1111, 0, 1'b1, 2'd0, 0);
    @(negedge clk); em_clear(); bus.ex_en = 1'b1; #2;
    chk("flush busy", 32'(bus.md_fwd_busy), 32'd1);
    @(negedge clk); bus.ex_en = 1'b0;
    em_drive(32'h1c00_0010, 32'h0, 1'b1, 5'd9, 4'b1111, 0, 1'b1, 2'd0, 0);
    @(negedge clk); em_clear(); bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEAD;
    #2;
    chk("stale ignored MW_valid", 32'(bus.MW_valid), 32'd0);
    chk("stale ignored busy", 32'(bus.md_fwd_busy), 32'd1);
    @(negedge clk); bus.data_sram_rdata = 32'hCAFE_F00D; #2;
    chk("lw MW_valid", 32'(bus.MW_valid), 32'd1);
    chk("lw wdata", bus.mw_rf_wdata, 32'hCAFE_F00D);

    // Back-to-back ALU ops
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.data_sram_data_ok = 1'b0;
      em_drive(32'h1c00_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 5'(i + 1), 4'd0,
               0, 0, 2'd0, 0);
      #2;
      if (i > 0) begin
        chk("b2b MW_valid", 32'(bus.MW_valid), 32'd1);
        chk("b2b allowin", 32'(bus.M_allowin), 32'd1);
        chk("b2b wdata", bus.mw_rf_wdata, 32'hA000_0000 + 32'(i - 1));
      end
    end
    @(negedge clk); em_clear(); #2;
    chk("b2b last", bus.mw_rf_wdata, 32'hA000_0004);

    // Randomized traffic; the responder only answers requests actually owed
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      bus.data_sram_data_ok = (outstanding > 0) && ($urandom_range(0, 2) == 0);
      bus.data_sram_rdata   = $urandom;
      bus.W_allowin         = ($urandom_range(0, 3) != 0);
      bus.ex_en             = ($urandom_range(0, 19) == 0);
      if (!hold) begin
        logic [3:0] res;
        logic       ex, req;
        case ($urandom_range(0, 3))
          0: res = 4'b0000;
          1: res = 4'b0001;
          2: res = 4'b0011;
          default: res = 4'b1111;
        endcase
        ex  = ($urandom_range(0, 9) == 0);
        req = (res != 0) || ($urandom_range(0, 3) == 0);
        if (ex) begin res = 4'd0; req = 1'b0; end
        em_drive($urandom, $urandom, 1'($urandom), 5'($urandom), res, 1'($urandom), req,
                 2'($urandom), ex);
        bus.EM_valid = ($urandom_range(0, 2) != 0);
      end
      #3;
      if (bus.data_sram_data_ok) outstanding--;
      if (bus.EM_valid && (bus.M_allowin || bus.ex_en)) begin
        if (bus.em_mem_req) outstanding++;
        hold = 0;
      end else begin
        hold = bus.EM_valid;
      end
    end

    // Drain every owed response
    @(negedge clk); em_clear(); bus.ex_en = 1'b0; bus.W_allowin = 1'b1;
    bus.data_sram_data_ok = 1'b0;
    for (int k = 0; k < 200 && outstanding > 0; k++) begin
      @(negedge clk); bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = $urandom;
      outstanding--;
    end
    @(negedge clk); bus.data_sram_data_ok = 1'b0;
    chk("drain outstanding", 32'(outstanding), 32'd0);
    @(negedge clk); #2;
    chk("drain empty MW_valid", 32'(bus.MW_valid), 32'd0);
    chk("drain empty allowin", 32'(bus.M_allowin), 32'd1);

    // Async reset mid-WAIT with a stale response still counted
    @(negedge clk); em_drive(32'h1c00_0200, 32'h0, 1'b1, 5'd3, 4'b1111, 0, 1'b1, 2'd0, 0);
    @(negedge clk); em_clear(); bus.ex_en = 1'b1;
    @(negedge clk); bus.ex_en = 1'b0;
    em_drive(32'h1c00_0204, 32'h0, 1'b1, 5'd4, 4'b1111, 0, 1'b1, 2'd0, 0);
    @(negedge clk); em_clear(); #2;
    chk("pre-reset busy", 32'(bus.md_fwd_busy), 32'd1);
    #1; rstn = 1'b0; #1;
    chk("async rst MW_valid", 32'(bus.MW_valid), 32'd0);
    chk("async rst allowin", 32'(bus.M_allowin), 32'd1);
    chk("async rst busy", 32'(bus.md_fwd_busy), 32'd0);
    chk("async rst fwd_dest", 32'(bus.md_fwd_dest), 32'd0);
    chk("async rst mw_pc", bus.mw_pc, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); em_drive(32'h1c00_0208, 32'h0, 1'b1, 5'd2, 4'b1111, 0, 1'b1, 2'd0, 0);
    @(negedge clk); em_clear(); bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h1122_3344;
    #2;
    chk("post-rst MW_valid", 32'(bus.MW_valid), 32'd1);
    chk("post-rst wdata", bus.mw_rf_wdata, 32'h1122_3344);
    @(negedge clk); bus.data_sram_data_ok = 1'b0;
    @(negedge clk); #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
